// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-0 single-word SPI master.
package spi_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(DATA_W);
  localparam int HW     = 3;

  localparam logic [1:0] DIV_2A = 2'b00;
  localparam logic [1:0] DIV_2B = 2'b01;
  localparam logic [1:0] DIV_4  = 2'b10;
  localparam logic [1:0] DIV_8  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // SCLK half-period in clk cycles for a given divide select.
  function automatic logic [HW-1:0] half_period(input logic [1:0] div);
    logic [HW-1:0] h;
    case (div)
      DIV_2A:  h = 3'd1;
      DIV_2B:  h = 3'd1;
      DIV_4:   h = 3'd2;
      DIV_8:   h = 3'd4;
      default: h = 3'd1;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host-side controls and SPI pins of the master, plus the FSM state for observation.
interface spi_master_if;
  import spi_pkg::*;

  // Handshake: a 0->1 step of SPI_start seen on consecutive clk edges while IDLE
  // launches one transfer; SPI_flag rises on completion and holds until the next accepted start.
  logic [DATA_W-1:0] SPI_data_trans;
  logic              SPI_MSB;
  logic              SPI_start;
  logic [1:0]        SPI_div;
  logic              SPI_miso;
  logic              SPI_mosi;
  logic              SPI_sclk;
  logic              SPI_slave_select;
  logic [DATA_W-1:0] SPI_data_rec;
  logic              SPI_flag;
  state_t            dbg_state;

  modport master (
    input  SPI_data_trans, SPI_MSB, SPI_start, SPI_div, SPI_miso,
    output SPI_mosi, SPI_sclk, SPI_slave_select, SPI_data_rec, SPI_flag, dbg_state
  );

  modport slave (
    output SPI_data_trans, SPI_MSB, SPI_start, SPI_div, SPI_miso,
    input  SPI_mosi, SPI_sclk, SPI_slave_select, SPI_data_rec, SPI_flag, dbg_state
  );

endinterface

// File: rtl/spi_clk_div.sv
// SCLK generator: toggles sclk every i_h enabled cycles and strobes the edge being produced.
module spi_clk_div
  import spi_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [HW-1:0] i_h,
  output logic          o_sclk,
  output logic          o_rise_tick,
  output logic          o_fall_tick
);

  logic [HW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_toggle;

  assign w_toggle    = i_en && (r_cnt == (i_h - 3'd1));
  // Strobes coincide with the clk edge on which sclk changes.
  assign o_rise_tick = w_toggle && !r_sclk;
  assign o_fall_tick = w_toggle &&  r_sclk;
  assign o_sclk      = r_sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_toggle) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-word mode-0 SPI master: start-edge launch, selectable bit order and SCLK divide.
module spi_master
  import spi_pkg::*;
(
  input  logic         clk,
  input  logic         SPI_reset,
  spi_master_if.master bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_start_d;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_data_rec;
  logic              r_msb;
  logic [HW-1:0]     r_h;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_flag;

  logic w_start_edge;
  logic w_div_en;
  logic w_sclk;
  logic w_rise;
  logic w_fall;
  logic w_last_fall;
  logic w_load;
  logic w_finish;
  logic w_ss;
  logic w_mosi;

  assign w_start_edge = bus.SPI_start & ~r_start_d;
  assign w_div_en     = (r_state == SHIFT);
  assign w_last_fall  = w_fall && (r_bit_cnt == CNT_W'(DATA_W - 1));

  spi_clk_div u_clk_div (
    .clk         (clk),
    .rst_n       (SPI_reset),
    .i_en        (w_div_en),
    .i_h         (r_h),
    .o_sclk      (w_sclk),
    .o_rise_tick (w_rise),
    .o_fall_tick (w_fall)
  );

  always_ff @(posedge clk or negedge SPI_reset) begin
    if (!SPI_reset) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_edge) w_state_nxt = SHIFT;
      SHIFT:   if (w_last_fall)  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pins are decoded from state so that reset deasserts them without a clk edge.
  always_comb begin
    w_load   = 1'b0;
    w_finish = 1'b0;
    w_ss     = 1'b1;
    w_mosi   = 1'b0;
    case (r_state)
      IDLE:  w_load = w_start_edge;
      SHIFT: begin
        w_finish = w_last_fall;
        w_ss     = 1'b0;
        w_mosi   = r_msb ? r_tx[DATA_W-1] : r_tx[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge SPI_reset) begin
    if (!SPI_reset) begin
      r_start_d  <= 1'b0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_data_rec <= '0;
      r_msb      <= 1'b1;
      r_h        <= 3'd1;
      r_bit_cnt  <= '0;
      r_flag     <= 1'b0;
    end else begin
      r_start_d <= bus.SPI_start;
      if (w_load) begin
        r_tx      <= bus.SPI_data_trans;
        r_msb     <= bus.SPI_MSB;
        r_h       <= half_period(bus.SPI_div);
        r_rx      <= '0;
        r_bit_cnt <= '0;
        r_flag    <= 1'b0;
      end else if (r_state == SHIFT) begin
        if (w_rise) begin
          if (r_msb) r_rx <= {r_rx[DATA_W-2:0], bus.SPI_miso};
          else       r_rx <= {bus.SPI_miso, r_rx[DATA_W-1:1]};
        end
        if (w_fall) begin
          if (r_msb) r_tx <= {r_tx[DATA_W-2:0], 1'b0};
          else       r_tx <= {1'b0, r_tx[DATA_W-1:1]};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        if (w_finish) begin
          r_data_rec <= r_rx;
          r_flag     <= 1'b1;
        end
      end
    end
  end

  assign bus.SPI_mosi         = w_mosi;
  assign bus.SPI_sclk         = w_sclk;
  assign bus.SPI_slave_select = w_ss;
  assign bus.SPI_data_rec     = r_data_rec;
  assign bus.SPI_flag         = r_flag;
  assign bus.dbg_state        = r_state;

endmodule

// File: tb/tb_spi_master.sv
// Directed, table-driven bench for spi_master with a mode-0 slave model on MISO.
module tb_spi_master;
  import spi_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       msb;
    logic [1:0] div;
    logic [7:0] miso;      // bit7 is driven first in time
    int         hold;      // cycles SPI_start stays high
    bit         poke;      // second start edge plus input changes mid-transfer
    logic [7:0] exp_mosi;  // bit7 is the first bit seen on MOSI
    logic [7:0] exp_rec;
    int         exp_ss;
    int         exp_h;
  } vec_t;

  logic clk;
  logic SPI_reset;
  int   n_checks;
  int   n_errors;
  logic [7:0] exp_q[$];
  vec_t vecs[7];

  spi_master_if bus();

  spi_master dut (
    .clk       (clk),
    .SPI_reset (SPI_reset),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_xfer(input vec_t v, output logic [7:0] mosi_seq, output logic [7:0] rec,
                         output int ss_len, output int hi_min, output int hi_max,
                         output logic flag_start, output logic flag_done, output bit timed_out);
    int   cyc, run, falls;
    bit   seen_low, done;
    logic prev;
    @(negedge clk);
    bus.SPI_start      = 1'b0;
    bus.SPI_data_trans = v.data;
    bus.SPI_MSB        = v.msb;
    bus.SPI_div        = v.div;
    bus.SPI_miso       = 1'b0;
    @(negedge clk);
    bus.SPI_start = 1'b1;
    cyc = 0; run = 0; falls = 0; seen_low = 0; done = 0; prev = 1'b0;
    ss_len = 0; hi_min = 1000; hi_max = 0; mosi_seq = '0; rec = '0;
    flag_start = 1'bx; flag_done = 1'bx;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == v.hold) bus.SPI_start = 1'b0;
      if (v.poke) begin
        if (cyc == 5) bus.SPI_start = 1'b0;
        if (cyc == 6) begin
          bus.SPI_start      = 1'b1;
          bus.SPI_data_trans = ~v.data;
          bus.SPI_div        = ~v.div;
          bus.SPI_MSB        = ~v.msb;
        end
        if (cyc == 7) bus.SPI_start = 1'b0;
      end
      if (!seen_low && !bus.SPI_slave_select) begin
        seen_low     = 1;
        flag_start   = bus.SPI_flag;
        bus.SPI_miso = v.miso[7];
      end
      if (!bus.SPI_slave_select) ss_len++;
      if (bus.SPI_sclk && !prev) mosi_seq = {mosi_seq[6:0], bus.SPI_mosi};
      if (bus.SPI_sclk) run++;
      if (!bus.SPI_sclk && prev) begin
        if (run < hi_min) hi_min = run;
        if (run > hi_max) hi_max = run;
        run = 0;
        falls++;
        if (falls < 8) bus.SPI_miso = v.miso[7 - falls];
      end
      prev = bus.SPI_sclk;
      if (seen_low && bus.SPI_slave_select) begin
        done      = 1;
        flag_done = bus.SPI_flag;
        rec       = bus.SPI_data_rec;
      end
    end
    timed_out = !done;
  endtask

  task automatic idle_watch(input int cycles, output int low_cnt);
    low_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (!bus.SPI_slave_select) low_cnt++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] mosi_seq, rec, exp_rec;
    int         ss_len, hi_min, hi_max, low_cnt;
    logic       flag_start, flag_done;
    bit         timed_out;
    exp_q.push_back(v.exp_rec);
    do_xfer(v, mosi_seq, rec, ss_len, hi_min, hi_max, flag_start, flag_done, timed_out);
    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    check({tag, "_mosi"}, 32'(mosi_seq), 32'(v.exp_mosi));
    exp_rec = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_rec"}, 32'(rec), 32'(exp_rec));
    check({tag, "_ss_len"}, 32'(ss_len), 32'(v.exp_ss));
    check({tag, "_hi_min"}, 32'(hi_min), 32'(v.exp_h));
    check({tag, "_hi_max"}, 32'(hi_max), 32'(v.exp_h));
    check({tag, "_flag_clr"}, 32'(flag_start), 32'd0);
    check({tag, "_flag_set"}, 32'(flag_done), 32'd1);
    idle_watch(24, low_cnt);
    check({tag, "_no_retrig"}, 32'(low_cnt), 32'd0);
  endtask

  initial begin
    int   rises;
    n_checks = 0;
    n_errors = 0;
    //            data  msb   div    miso  hold poke  mosi   rec   ss  H
    vecs[0] = '{8'h0F, 1'b1, 2'b01, 8'hA5, 1,  1'b0, 8'h0F, 8'hA5, 16, 1};
    vecs[1] = '{8'hF0, 1'b0, 2'b10, 8'h3C, 1,  1'b0, 8'h0F, 8'h3C, 32, 2};
    vecs[2] = '{8'hC3, 1'b0, 2'b00, 8'h96, 1,  1'b0, 8'hC3, 8'h69, 16, 1};
    vecs[3] = '{8'h5A, 1'b1, 2'b10, 8'h3C, 2,  1'b1, 8'h5A, 8'h3C, 32, 2};
    vecs[4] = '{8'h33, 1'b1, 2'b01, 8'h0F, 40, 1'b0, 8'h33, 8'h0F, 16, 1};
    vecs[5] = '{8'h81, 1'b1, 2'b11, 8'hFF, 1,  1'b0, 8'h81, 8'hFF, 64, 4};
    vecs[6] = '{8'hE1, 1'b0, 2'b01, 8'h5B, 3,  1'b0, 8'h87, 8'hDA, 16, 1};

    SPI_reset          = 1'b0;
    bus.SPI_start      = 1'b0;
    bus.SPI_data_trans = 8'h00;
    bus.SPI_MSB        = 1'b1;
    bus.SPI_div        = 2'b00;
    bus.SPI_miso       = 1'b0;
    repeat (3) @(negedge clk);
    SPI_reset = 1'b1;
    @(negedge clk);
    check("rst_ss", 32'(bus.SPI_slave_select), 32'd1);
    check("rst_sclk", 32'(bus.SPI_sclk), 32'd0);
    check("rst_mosi", 32'(bus.SPI_mosi), 32'd0);
    check("rst_flag", 32'(bus.SPI_flag), 32'd0);
    check("rst_rec", 32'(bus.SPI_data_rec), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a slow transfer, checked before any further clk edge.
    @(negedge clk);
    bus.SPI_start      = 1'b0;
    bus.SPI_data_trans = 8'hFF;
    bus.SPI_MSB        = 1'b1;
    bus.SPI_div        = 2'b11;
    bus.SPI_miso       = 1'b1;
    @(negedge clk);
    bus.SPI_start = 1'b1;
    rises = 0;
    for (int c = 0; c < 200 && rises < 3; c++) begin
      logic p;
      p = bus.SPI_sclk;
      @(negedge clk);
      if (bus.SPI_sclk && !p) rises++;
    end
    check("mid_rises", 32'(rises), 32'd3);
    check("mid_mosi_pre", 32'(bus.SPI_mosi), 32'd1);
    SPI_reset = 1'b0;
    #1;
    check("mid_ss", 32'(bus.SPI_slave_select), 32'd1);
    check("mid_sclk", 32'(bus.SPI_sclk), 32'd0);
    check("mid_mosi", 32'(bus.SPI_mosi), 32'd0);
    check("mid_flag", 32'(bus.SPI_flag), 32'd0);
    check("mid_rec", 32'(bus.SPI_data_rec), 32'd0);
    check("mid_state", 32'(bus.dbg_state), 32'(IDLE));
    bus.SPI_start = 1'b0;
    @(negedge clk);
    SPI_reset = 1'b1;

    run_vec(vecs[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), full duplex.
- Shifts out an 8-bit word on SPI_mosi and captures 8 bits from SPI_miso into SPI_data_rec.
- Bit order and SCLK divide ratio are selectable per transfer.
- Sits between a host register interface and one external SPI slave.

Parameters:
- DATA_W, 8, transfer word width; all behaviour below assumes 8.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- SPI_reset  input  1  asynchronous, active-low reset.
- SPI_data_trans  input  8  word to transmit; latched at transfer start.
- SPI_MSB  input  1  1 = MSB first, 0 = LSB first; latched at start.
- SPI_start  input  1  a rising edge (0 then 1 on consecutive clk edges) requests a transfer.
- SPI_div  input  2  SCLK divide select; latched at start.
- SPI_miso  input  1  serial data from the slave.
- SPI_mosi  output  1  serial data to the slave.
- SPI_sclk  output  1  SPI clock; idles low.
- SPI_slave_select  output  1  active-low chip select.
- SPI_data_rec  output  8  last completed received word.
- SPI_flag  output  1  transfer-complete flag.

Behaviour:
- Reset (SPI_reset=0, asynchronous) forces all of the following:
  - state IDLE, SPI_sclk=0, SPI_mosi=0, SPI_slave_select=1, SPI_data_rec=8'h00, SPI_flag=0;
  - start edge detector cleared.
- Reset mid-transfer aborts immediately: no flag, SPI_data_rec unchanged from its reset value.
- Half-period H in clk cycles, from SPI_div:
  - 00 gives 1 (clk/2), 01 gives 1 (clk/2), 10 gives 2 (clk/4), 11 gives 4 (clk/8).
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On a SPI_start rising edge, on that same clk edge the block:
    - latches data, SPI_MSB and H;
    - drives SPI_slave_select=0;
    - drives SPI_mosi to the first bit (bit7 if MSB, else bit0);
    - keeps SPI_sclk=0, clears SPI_flag and the bit counter;
    - moves to SHIFT.
  - A level-high SPI_start with no edge never starts a transfer.
- SHIFT:
  - Every H clk cycles SPI_sclk toggles.
  - On each SCLK rise, SPI_miso is sampled into the receive shift register:
    - MSB mode: shift left, new bit into bit0, so the first bit received lands in bit7;
    - LSB mode: shift right, new bit into bit7, so the first bit received lands in bit0.
  - On each SCLK fall, SPI_mosi advances to the next transmit bit.
  - After the 8th falling edge the block moves to DONE. Total time in SHIFT is 16*H clk cycles.
- DONE (one cycle):
  - SPI_slave_select=1, SPI_mosi=0, SPI_sclk=0.
  - SPI_data_rec = received word.
  - SPI_flag=1.
  - Returns to IDLE.
- SPI_flag stays high until the next accepted start edge clears it.
- SPI_data_rec holds its value until the next transfer completes.
- Start edges during SHIFT or DONE are ignored; they are not queued.
- Changes to SPI_data_trans, SPI_MSB or SPI_div during a transfer have no effect until the next start.

Decomposition:
- Package spi_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - SPI_div encoding constants and the H lookup function;
  - DATA_W.
- Sub-module spi_clk_div:
  - counts H cycles while enabled;
  - emits one-cycle rise_tick and fall_tick strobes plus sclk;
  - cleared whenever idle.
- The top level holds the FSM, shift registers and bit counter.

Test Plan:
- MSB-first, clk/2:
  - Stimulus: SPI_data_trans=8'h0F, SPI_MSB=1, SPI_div=01; the bench drives MISO bits 1,0,1,0,0,1,0,1, each one valid at the corresponding SCLK rise.
  - Response: MOSI sequence 0,0,0,0,1,1,1,1; SS low for exactly 16 clk; SPI_data_rec=8'hA5; SPI_flag=1.
- LSB-first, clk/4:
  - Stimulus: SPI_data_trans=8'hF0, SPI_MSB=0, SPI_div=10; MISO bits 0,0,1,1,1,1,0,0 in time order.
  - Response: MOSI sequence 0,0,0,0,1,1,1,1; SS low for 32 clk; SPI_data_rec=8'h3C; each SCLK high phase lasts 2 clk.
- Held start:
  - Stimulus: SPI_start held high for 2 to 40 cycles.
  - Response: exactly one transfer; after completion, no retrigger until SPI_start goes low and then high again.
- Busy start and mid-transfer changes:
  - Stimulus: a second start edge during SHIFT, plus SPI_data_trans and SPI_div changed mid-transfer.
  - Response: ignored; the current transfer completes unchanged.
- Reset mid-transfer:
  - Stimulus: SPI_reset pulsed low after the 3rd SCLK rise.
  - Response: SS=1, SCLK=0, MOSI=0, SPI_flag=0, SPI_data_rec=8'h00 immediately, with no clk edge needed.
- Slowest divide:
  - Stimulus: SPI_div=11, data 8'h81, MISO tied 1.
  - Response: SS low for 64 clk; SPI_data_rec=8'hFF; SPI_flag clears on the next start edge.
